// File: rtl/pc_fetch_unit.sv
// RV32I program counter, next-PC selection and instruction-fetch handshake.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being truncated.
//
// state    | meaning
// ST_BOOT  | first cycle after reset release, no fetch issued
// ST_FETCH | fetching at pc, retiring whenever memory is ready and not stalled
// ST_TRAP  | misaligned redirect seen, fetch halted until reset
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [31:0] instret,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] target;
  logic        redirect;
  logic        retire;

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  assign retire   = (state_q == ST_FETCH) && imem_ready && !stall;
  assign redirect = jalr || jump || pc_src;

  // jalr clears bit 0 of its sum; jump and branch share the pc-relative adder
  always_comb begin
    target = pc_q + 32'd4;
    if (jalr)
      target = (rs1_data + imm) & ~32'h1;
    else if (jump || pc_src)
      target = pc_q + imm;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
`ifdef MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (retire) begin
          instret_d = instret_q + 32'd1;
`ifdef MISALIGN_TRAP_EN
          if (redirect && (target[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
            state_d      = ST_TRAP;
          end else begin
            pc_d = target;
          end
`else
          pc_d = redirect ? (target & ~32'h3) : target;
`endif
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VECTOR;
      instret_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_FETCH) && imem_ready;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instret     = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, corner sequences, random vs. model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src, jump, jalr, stall, imem_ready;
  logic [31:0] imm, rs1_data;
  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, pc, pc_plus4, instret;

  int n_vec = 0;
  int n_err = 0;

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jump(jump), .jalr(jalr),
    .imm(imm), .rs1_data(rs1_data), .stall(stall), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .instret(instret), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_src, jump, jalr, stall, ready;
    logic [31:0] imm, rs1, exp_pc, exp_ret;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic ps, logic j, logic jr, logic st, logic rd,
                              logic [31:0] im, logic [31:0] r1,
                              logic [31:0] epc, logic [31:0] ert);
    vec_t v;
    v.pc_src = ps; v.jump = j; v.jalr = jr; v.stall = st; v.ready = rd;
    v.imm = im; v.rs1 = r1; v.exp_pc = epc; v.exp_ret = ert;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ps, input logic j, input logic jr, input logic st,
                       input logic rd, input logic [31:0] im, input logic [31:0] r1);
    pc_src = ps; jump = j; jalr = jr; stall = st; imem_ready = rd; imm = im; rs1_data = r1;
  endtask

  // leaves the DUT in FETCH at pc=RESET_VECTOR, 1 time unit after an edge
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // behavioural reference state
  logic [31:0] m_pc, m_ret;
  logic        m_trap, m_mis;

  task automatic model_edge();
    logic [31:0] tgt;
    logic        redir;
    if (!m_trap && imem_ready && !stall) begin
      m_ret = m_ret + 1;
      redir = 1'b1;
      if (jalr)                tgt = (rs1_data + imm) & ~32'h1;
      else if (jump || pc_src) tgt = m_pc + imm;
      else begin               tgt = m_pc + 4; redir = 1'b0; end
`ifdef MISALIGN_TRAP_EN
      if (redir && (tgt % 4 != 0)) begin
        m_trap = 1'b1;
        m_mis  = 1'b1;
      end else m_pc = tgt;
`else
      if (redir) m_pc = tgt - (tgt % 4);
      else       m_pc = tgt;
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);

    vecs[0]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_0004, 1);
    vecs[1]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_0008, 2);
    vecs[2]  = mk(0, 1, 0, 0, 1, 32'h8,         32'h0,         32'h0000_0010, 3);
    vecs[3]  = mk(1, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008, 4);
    vecs[4]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_000C, 5);
    vecs[5]  = mk(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'h0,         32'h0000_0010, 6);
    vecs[6]  = mk(0, 1, 1, 0, 1, 32'h4,         32'h0000_0101, 32'h0000_0104, 7);
    vecs[7]  = mk(1, 0, 0, 0, 0, 32'h100,       32'h0,         32'h0000_0104, 7);
    vecs[8]  = mk(1, 0, 0, 1, 1, 32'h100,       32'h0,         32'h0000_0104, 7);
    vecs[9]  = mk(0, 0, 1, 0, 1, 32'h0000_000C, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 8);
    vecs[10] = mk(0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_0000, 9);

    // reset and boot cycle
    @(posedge clk); @(posedge clk); #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_mis", {31'b0, misaligned}, 32'h0);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    #1;
    check("boot_req", {31'b0, imem_req}, 32'h0);
    check("boot_valid", {31'b0, instr_valid}, 32'h0);
    @(posedge clk); #1;
    check("fetch0_req", {31'b0, imem_req}, 32'h1);
    check("fetch0_pc", pc, 32'h0);

    // directed table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].pc_src, vecs[i].jump, vecs[i].jalr, vecs[i].stall,
            vecs[i].ready, vecs[i].imm, vecs[i].rs1);
      #1;
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].ready});
      check($sformatf("v%0d_plus4", i), pc_plus4, imem_addr + 32'd4);
      @(posedge clk); #1;
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_instret", i), instret, vecs[i].exp_ret);
    end

    // memory wait at 0x40, then stall with a branch pending
    do_reset();
    drive(0, 1, 0, 0, 1, 32'h40, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_req", {31'b0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h40);
      check("wait_valid", {31'b0, instr_valid}, 32'h0);
      @(posedge clk); #1;
      check("wait_instret", instret, 32'h1);
    end
    drive(1, 0, 0, 1, 1, 32'h100, 32'h0);
    @(posedge clk); #1;
    check("stall_pc", pc, 32'h40);
    check("stall_instret", instret, 32'h1);

    // misaligned branch target from pc 0
    do_reset();
    drive(1, 0, 0, 0, 1, 32'h6, 32'h0);
    @(posedge clk); #1;
    check("mis_instret", instret, 32'h1);
`ifdef MISALIGN_TRAP_EN
    check("mis_pc", pc, 32'h0);
    check("mis_flag", {31'b0, misaligned}, 32'h1);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      check("trap_req", {31'b0, imem_req}, 32'h0);
      check("trap_valid", {31'b0, instr_valid}, 32'h0);
      check("trap_pc", pc, 32'h0);
    end
`else
    check("mis_pc", pc, 32'h4);
    check("mis_flag", {31'b0, misaligned}, 32'h0);
`endif

    // asynchronous reset in the middle of a memory wait at 0x80
    do_reset();
    drive(0, 1, 0, 0, 1, 32'h80, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    #3;
    check("pre_arst_pc", pc, 32'h80);
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_instret", instret, 32'h0);
    check("arst_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk); #1;

    // randomized run against the reference model
    do_reset();
    m_pc = 32'h0; m_ret = 32'h0; m_trap = 1'b0; m_mis = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        m_pc = 32'h0; m_ret = 32'h0; m_trap = 1'b0; m_mis = 1'b0;
      end
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & ~32'h3),
            ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & ~32'h3));
      #1;
      check("rnd_req", {31'b0, imem_req}, {31'b0, !m_trap});
      check("rnd_valid", {31'b0, instr_valid}, {31'b0, !m_trap && imem_ready});
      check("rnd_addr", imem_addr, m_pc);
      check("rnd_plus4", pc_plus4, m_pc + 32'd4);
      check("rnd_instret", instret, m_ret);
      check("rnd_mis", {31'b0, misaligned}, {31'b0, m_mis});
      model_edge();
      @(posedge clk); #1;
      check("rnd_pc", pc, m_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
